// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC iteration controller: FSM encoding,
// the pre-scaled start vector and the arctangent table.
package cordic_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } ctrl_state_t;

    // 0.6072529 * 2^30, the inverse CORDIC gain at high precision.
    localparam logic [63:0] KSCALE_30 = 64'd652032836;

    // round(0.6072529 * 2^(dw-2)); valid for dw up to 31.
    function automatic logic [31:0] kscale(input int dw);
        logic [63:0] full;
        full = KSCALE_30 + (64'd1 << (31 - dw));
        return 32'(full >> (32 - dw));
    endfunction

    // atan(2^-k) with a full turn = 2^32.
    function automatic logic [31:0] atan32(input logic [4:0] k);
        case (k)
            5'd0:    return 32'h20000000;
            5'd1:    return 32'h12E4051E;
            5'd2:    return 32'h09FB385B;
            5'd3:    return 32'h051111D4;
            5'd4:    return 32'h028B0D43;
            5'd5:    return 32'h0145D7E1;
            5'd6:    return 32'h00A2F61E;
            5'd7:    return 32'h00517C55;
            5'd8:    return 32'h0028BE53;
            5'd9:    return 32'h00145F2F;
            5'd10:   return 32'h000A2F98;
            5'd11:   return 32'h000517CC;
            5'd12:   return 32'h00028BE6;
            5'd13:   return 32'h000145F3;
            5'd14:   return 32'h0000A2FA;
            5'd15:   return 32'h0000517D;
            5'd16:   return 32'h000028BE;
            5'd17:   return 32'h0000145F;
            5'd18:   return 32'h00000A30;
            5'd19:   return 32'h00000518;
            5'd20:   return 32'h0000028C;
            5'd21:   return 32'h00000146;
            5'd22:   return 32'h000000A3;
            5'd23:   return 32'h00000051;
            5'd24:   return 32'h00000029;
            5'd25:   return 32'h00000014;
            5'd26:   return 32'h0000000A;
            5'd27:   return 32'h00000005;
            5'd28:   return 32'h00000003;
            5'd29:   return 32'h00000001;
            5'd30:   return 32'h00000001;
            default: return 32'h00000000;
        endcase
    endfunction

    // round(atan(2^-k) * 2^dw / (2*pi)); valid for dw up to 31.
    function automatic logic [31:0] atan_scaled(input int dw, input logic [4:0] k);
        logic [63:0] full;
        full = {32'd0, atan32(k)} + (64'd1 << (31 - dw));
        return 32'(full >> (32 - dw));
    endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent table indexed by iteration number.
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int DATA_WIDTH = 18,
    parameter int CNT_W      = 5
) (
    input  logic [CNT_W-1:0]      i_k,
    output logic [DATA_WIDTH-1:0] o_atan
);

    // Table lookup, rounded to the phase resolution of the datapath.
    always_comb begin
        o_atan = DATA_WIDTH'(atan_scaled(DATA_WIDTH, 5'(i_k)));
    end

endmodule

// File: rtl/cordic_iter_ctrl.sv
// Sequencer driving one external CORDIC rotation stage for N_ITER passes.
// Stream handshakes: a transfer happens on a rising edge where valid and
// ready are both high; valid, once raised, holds its payload until accepted.
module cordic_iter_ctrl
    import cordic_pkg::*;
#(
    parameter int DATA_WIDTH = 18,
    parameter int N_ITER     = 16,
    parameter int CNT_W      = $clog2(N_ITER) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_phase,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_cos,
    output logic [DATA_WIDTH-1:0] o_sin,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] eng_x,
    output logic [DATA_WIDTH-1:0] eng_y,
    output logic [DATA_WIDTH-1:0] eng_alpha,
    output logic [DATA_WIDTH-1:0] eng_atan,
    output logic [CNT_W-1:0]      eng_count,
    output logic [1:0]            eng_quadrant,
    output logic                  eng_valid,
    input  logic [DATA_WIDTH-1:0] eng_x_o,
    input  logic [DATA_WIDTH-1:0] eng_y_o,
    input  logic [DATA_WIDTH-1:0] eng_alpha_o,
    input  logic                  eng_valid_o
);

    localparam logic [DATA_WIDTH-1:0] KSCALE = DATA_WIDTH'(kscale(DATA_WIDTH));
    localparam logic [CNT_W-1:0]      K_LAST = CNT_W'(N_ITER - 1);

    ctrl_state_t           state_q, state_d;
    logic [CNT_W-1:0]      k_q, k_d;
    logic [1:0]            q_q, q_d;
    logic [DATA_WIDTH-1:0] alpha0_q, alpha0_d;
    logic                  o_valid_q, o_valid_d;
    logic [DATA_WIDTH-1:0] cos_q, cos_d;
    logic [DATA_WIDTH-1:0] sin_q, sin_d;
    logic [DATA_WIDTH-1:0] neg_x, neg_y;

    assign neg_x = {DATA_WIDTH{1'b0}} - eng_x_o;
    assign neg_y = {DATA_WIDTH{1'b0}} - eng_y_o;

    // First pass starts from the reduced angle; later passes feed back.
    assign eng_x        = (k_q == '0) ? KSCALE   : eng_x_o;
    assign eng_y        = (k_q == '0) ? '0       : eng_y_o;
    assign eng_alpha    = (k_q == '0) ? alpha0_q : eng_alpha_o;
    assign eng_count    = k_q;
    assign eng_quadrant = q_q;
    assign eng_valid    = (state_q == S_ITER);
    assign o_ready      = (state_q == S_IDLE);
    assign o_valid      = o_valid_q;
    assign o_cos        = cos_q;
    assign o_sin        = sin_q;

    cordic_atan_rom #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_W      (CNT_W)
    ) u_atan_rom (
        .i_k    (k_q),
        .o_atan (eng_atan)
    );

    // Next-state logic: reduce, iterate, undo the quadrant, hold result.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        q_d       = q_q;
        alpha0_d  = alpha0_q;
        o_valid_d = o_valid_q;
        cos_d     = cos_q;
        sin_d     = sin_q;
        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    q_d      = i_phase[DATA_WIDTH-1 -: 2];
                    alpha0_d = {2'b00, i_phase[DATA_WIDTH-3:0]};
                    k_d      = '0;
                    state_d  = S_ITER;
                end
            end
            S_ITER: begin
                if ((k_q != '0) && !eng_valid_o) begin
                    // Feedback missing: drop the operation silently.
                    k_d     = '0;
                    state_d = S_IDLE;
                end else if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = S_FIX;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_FIX: begin
                if (!eng_valid_o) begin
                    state_d = S_IDLE;
                end else begin
                    case (q_q)
                        2'd0:    begin cos_d = eng_x_o; sin_d = eng_y_o; end
                        2'd1:    begin cos_d = neg_y;   sin_d = eng_x_o; end
                        2'd2:    begin cos_d = neg_x;   sin_d = neg_y;   end
                        default: begin cos_d = eng_y_o; sin_d = neg_x;   end
                    endcase
                    o_valid_d = 1'b1;
                    state_d   = S_DONE;
                end
            end
            default: begin
                if (i_ready) begin
                    o_valid_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
        endcase
    end

    // State and registered outputs; reset abandons any operation.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            q_q       <= '0;
            alpha0_q  <= '0;
            o_valid_q <= 1'b0;
            cos_q     <= '0;
            sin_q     <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            q_q       <= q_d;
            alpha0_q  <= alpha0_d;
            o_valid_q <= o_valid_d;
            cos_q     <= cos_d;
            sin_q     <= sin_d;
        end
    end

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Bench for cordic_iter_ctrl with a behavioural one-stage CORDIC engine.
module tb_cordic_iter_ctrl;

    localparam int DW  = 18;
    localparam int NI  = 16;
    localparam int CW  = $clog2(NI) + 1;
    localparam int TOL = 8;
    localparam int BOUND = 200;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [DW-1:0] i_phase = '0;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [DW-1:0] o_cos, o_sin;
    logic          o_valid;
    logic          i_ready = 1'b1;
    logic [DW-1:0] eng_x, eng_y, eng_alpha, eng_atan;
    logic [CW-1:0] eng_count;
    logic [1:0]    eng_quadrant;
    logic          eng_valid;
    logic [DW-1:0] eng_x_o, eng_y_o, eng_alpha_o;
    logic          eng_valid_o;

    cordic_iter_ctrl #(.DATA_WIDTH(DW), .N_ITER(NI), .CNT_W(CW)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_phase      (i_phase),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .o_cos        (o_cos),
        .o_sin        (o_sin),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .eng_x        (eng_x),
        .eng_y        (eng_y),
        .eng_alpha    (eng_alpha),
        .eng_atan     (eng_atan),
        .eng_count    (eng_count),
        .eng_quadrant (eng_quadrant),
        .eng_valid    (eng_valid),
        .eng_x_o      (eng_x_o),
        .eng_y_o      (eng_y_o),
        .eng_alpha_o  (eng_alpha_o),
        .eng_valid_o  (eng_valid_o)
    );

    // ---------------- engine model ----------------
    logic drop_en = 1'b0;
    logic signed [DW-1:0] nx, ny, na;
    logic signed [DW-1:0] ex_q, ey_q, ea_q;
    logic                 ev_q;

    always_comb begin
        if ($signed(eng_alpha) >= 0) begin
            nx = $signed(eng_x) - ($signed(eng_y) >>> eng_count);
            ny = $signed(eng_y) + ($signed(eng_x) >>> eng_count);
            na = $signed(eng_alpha) - $signed(eng_atan);
        end else begin
            nx = $signed(eng_x) + ($signed(eng_y) >>> eng_count);
            ny = $signed(eng_y) - ($signed(eng_x) >>> eng_count);
            na = $signed(eng_alpha) + $signed(eng_atan);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q <= '0;
            ey_q <= '0;
            ea_q <= '0;
            ev_q <= 1'b0;
        end else begin
            ev_q <= eng_valid;
            if (eng_valid) begin
                ex_q <= nx;
                ey_q <= ny;
                ea_q <= na;
            end
        end
    end

    assign eng_x_o     = ex_q;
    assign eng_y_o     = ey_q;
    assign eng_alpha_o = ea_q;
    assign eng_valid_o = ev_q && !(drop_en && eng_valid && (eng_count == CW'(5)));

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    int ov_cnt = 0;
    int ev_cnt = 0;
    logic [2*DW-1:0] exp_q[$];

    task automatic check_eq(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic check_close(input string name, input logic [DW-1:0] act, input int req);
        int a;
        a = int'($signed(act));
        total++;
        if ((a - req > TOL) || (req - a > TOL)) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d+-%0d", name, a, req, TOL);
        end
    endtask

    // Consumer side: compare when a result transfer is about to happen.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_valid) ov_cnt++;
            if (eng_valid) ev_cnt++;
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result actual=o_valid required=no_pending_result");
                end else begin
                    logic [2*DW-1:0] e;
                    e = exp_q.pop_front();
                    check_close("cos", o_cos, int'($signed(e[2*DW-1:DW])));
                    check_close("sin", o_sin, int'($signed(e[DW-1:0])));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Call just after a rising edge; returns #1 after the accept edge.
    task automatic send(input logic [DW-1:0] ph, input int ec, input int es);
        logic acc;
        int   n;
        logic [DW-1:0] c, s;
        acc = 1'b0;
        n   = 0;
        i_phase = ph;
        i_valid = 1'b1;
        while (!acc && n < BOUND) begin
            @(negedge clk);
            acc = o_ready;
            @(posedge clk);
            #1;
            n++;
        end
        i_valid = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL accept_timeout actual=no_accept required=accept");
        end else begin
            c = ec[DW-1:0];
            s = es[DW-1:0];
            exp_q.push_back({c, s});
        end
    endtask

    // Edges from the accept edge to the edge where the consumer samples o_valid.
    task automatic wait_result(output int lat, output logic [1:0] quad);
        logic seen;
        seen = 1'b0;
        lat  = 0;
        quad = '0;
        while (!seen && lat < BOUND) begin
            @(negedge clk);
            if (o_valid) begin
                seen = 1'b1;
                quad = eng_quadrant;
            end else begin
                @(posedge clk);
                #1;
                lat++;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL result_timeout actual=no_o_valid required=o_valid");
        end
        @(posedge clk);
        #1;
        lat++;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        logic [DW-1:0] phase;
        int            cos_e;
        int            sin_e;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int            lat;
        logic [1:0]    quad;
        int            ov_snap;
        logic          rdy_low;
        logic [DW-1:0] c0, s0;
        logic          hit;

        vecs[0] = '{18'h00000,  65536,      0};
        vecs[1] = '{18'h08000,  46341,  46341};
        vecs[2] = '{18'h10000,      0,  65536};
        vecs[3] = '{18'h20000, -65536,      0};
        vecs[4] = '{18'h30000,      0, -65536};
        vecs[5] = '{18'h04000,  60547,  25080};
        vecs[6] = '{18'h14000, -25080,  60547};
        vecs[7] = '{18'h2C000, -25080, -60547};
        vecs[8] = '{18'h3C000,  60547, -25080};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_o_valid", int'(o_valid), 0);
        check_eq("rst_o_cos", int'(o_cos), 0);
        check_eq("rst_o_sin", int'(o_sin), 0);
        check_eq("rst_eng_valid", int'(eng_valid), 0);
        check_eq("rst_eng_count", int'(eng_count), 0);
        check_eq("rst_eng_quadrant", int'(eng_quadrant), 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_o_ready", int'(o_ready), 1);
        @(posedge clk);
        #1;

        // Table: every quadrant, latency, iteration count, quadrant pass-through.
        i_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            ev_cnt = 0;
            send(vecs[i].phase, vecs[i].cos_e, vecs[i].sin_e);
            wait_result(lat, quad);
            check_eq("latency", lat, NI + 2);
            check_eq("eng_valid_cycles", ev_cnt, NI);
            check_eq("eng_quadrant", int'(quad), int'(vecs[i].phase[DW-1 -: 2]));
            idle_cycles(2);
        end

        // Back-pressure with the next phase already waiting.
        i_ready = 1'b0;
        send(18'h08000, 46341, 46341);
        i_phase = 18'h10000;
        i_valid = 1'b1;
        rdy_low = 1'b1;
        hit     = 1'b0;
        for (int n = 0; n < BOUND && !hit; n++) begin
            @(negedge clk);
            if (o_ready) rdy_low = 1'b0;
            if (o_valid) hit = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check_eq("bp_o_valid_rises", int'(hit), 1);
        check_eq("bp_ready_low_busy", int'(rdy_low), 1);
        c0 = o_cos;
        s0 = o_sin;
        check_close("bp_cos_hold_value", c0, 46341);
        @(posedge clk);
        #1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check_eq("bp_o_valid_hold", int'(o_valid), 1);
            check_eq("bp_cos_stable", int'(o_cos), int'(c0));
            check_eq("bp_sin_stable", int'(o_sin), int'(s0));
            check_eq("bp_o_ready_low", int'(o_ready), 0);
            @(posedge clk);
            #1;
        end
        i_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_ready_low_done", int'(o_ready), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("bp_o_valid_cleared", int'(o_valid), 0);
        check_eq("bp_o_ready_back", int'(o_ready), 1);
        @(posedge clk);
        #1;
        exp_q.push_back({18'sd0, 18'sd65536});
        i_valid = 1'b0;
        @(negedge clk);
        check_eq("bp_next_accepted", int'(o_ready), 0);
        @(posedge clk);
        #1;
        ev_cnt = 0;
        wait_result(lat, quad);
        check_eq("bp_next_latency", lat, NI + 1);
        idle_cycles(2);

        // Asynchronous reset in the middle of ITER.
        send(18'h08000, 46341, 46341);
        hit = 1'b0;
        for (int n = 0; n < BOUND && !hit; n++) begin
            @(negedge clk);
            if (eng_valid && eng_count == CW'(7)) hit = 1'b1;
        end
        check_eq("rst_mid_reach_k7", int'(hit), 1);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_o_valid", int'(o_valid), 0);
        check_eq("rst_mid_eng_valid", int'(eng_valid), 0);
        check_eq("rst_mid_o_cos", int'(o_cos), 0);
        check_eq("rst_mid_o_sin", int'(o_sin), 0);
        check_eq("rst_mid_eng_count", int'(eng_count), 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        ov_snap = ov_cnt;
        idle_cycles(NI + 8);
        check_eq("rst_mid_no_result", ov_cnt - ov_snap, 0);
        @(negedge clk);
        check_eq("rst_mid_ready", int'(o_ready), 1);
        @(posedge clk);
        #1;
        send(18'h04000, 60547, 25080);
        wait_result(lat, quad);
        check_eq("rst_mid_fresh_latency", lat, NI + 2);
        idle_cycles(2);

        // Engine drops its valid at k=5.
        drop_en = 1'b1;
        send(18'h08000, 46341, 46341);
        hit = 1'b0;
        for (int n = 0; n < BOUND && !hit; n++) begin
            @(negedge clk);
            if (eng_valid && eng_count == CW'(5)) hit = 1'b1;
        end
        check_eq("drop_reach_k5", int'(hit), 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("drop_o_ready", int'(o_ready), 1);
        check_eq("drop_eng_valid", int'(eng_valid), 0);
        exp_q.delete();
        drop_en = 1'b0;
        ov_snap = ov_cnt;
        idle_cycles(NI + 8);
        check_eq("drop_no_result", ov_cnt - ov_snap, 0);

        // Normal operation resumes afterwards.
        send(18'h30000, 0, -65536);
        wait_result(lat, quad);
        check_eq("post_drop_latency", lat, NI + 2);
        idle_cycles(3);
        check_eq("pending_results", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cordic_iter_ctrl.md
Name: cordic_iter_ctrl

Overview:
- Sequencer that time-multiplexes one CORDIC_Engine rotation stage over N_ITER iterations to compute cos/sin of a phase word.
- Performs quadrant reduction on input, supplies shift count and atan constant per iteration, feeds engine outputs back, and applies quadrant correction on the result.
- Sits between the phase-source valid/ready stream and the sin/cos consumer; the engine instance is external and connected through the eng_* ports.

Parameters:
- DATA_WIDTH, 18, datapath width; phase full scale 2^DATA_WIDTH = 2*pi.
- N_ITER, 16, CORDIC iterations per operation (1..DATA_WIDTH-2).
- CNT_W, $clog2(N_ITER)+1, width of shift-count bus to engine.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_phase  in  DATA_WIDTH  unsigned phase, 0..2^DATA_WIDTH-1
- i_valid  in  1  phase valid
- o_ready  out  1  controller can accept phase
- o_cos  out  DATA_WIDTH  signed cosine, amplitude 2^(DATA_WIDTH-2)
- o_sin  out  DATA_WIDTH  signed sine, same scale
- o_valid  out  1  result valid, held until i_ready
- i_ready  in  1  consumer accepts result
- eng_x, eng_y, eng_alpha, eng_atan  out  DATA_WIDTH  engine operands
- eng_count  out  CNT_W  iteration index / shift amount
- eng_quadrant  out  2  stored quadrant (pass-through)
- eng_valid  out  1  engine valid_in
- eng_x_o, eng_y_o, eng_alpha_o  in  DATA_WIDTH  engine registered outputs
- eng_valid_o  in  1  engine valid_out

Behaviour:
- Reset (async, i_rst=1): state IDLE, o_valid=0, o_cos=o_sin=0, eng_valid=0, counter=0, stored quadrant=0. o_ready=1 once reset deasserts. Reset mid-operation abandons the operation; no o_valid is produced for it.
- States: IDLE -> ITER -> FIX -> DONE -> IDLE.
- IDLE: o_ready=1. On i_valid&o_ready at edge T: latch q=i_phase[DW-1:DW-2]; alpha0 = zero-extended i_phase[DW-3:0] (range [0, pi/2)); x0=KSCALE=round(0.6072529*2^(DW-2)) (39797 for DW=18); y0=0; k=0. Go to ITER.
- ITER: eng_valid=1 for exactly N_ITER consecutive cycles (T+1..T+N_ITER); eng_count=k; eng_atan=ATAN[k].
  - k=0: operands are the latched x0/y0/alpha0.
  - k>=1: operands are eng_x_o/eng_y_o/eng_alpha_o, combinationally muxed.
  - k increments each cycle. After issuing k=N_ITER-1, go to FIX.
- FIX (cycle T+N_ITER+1): eng_valid_o=1 with final x,y. Register the quadrant-corrected result:
  - q0: (x,y)
  - q1: (-y,x)
  - q2: (-x,-y)
  - q3: (y,-x)
  - Two's-complement negation. Magnitudes are <= 2^(DW-2)+16, so no overflow.
  - Go to DONE.
- DONE: o_valid=1 from cycle T+N_ITER+2, with o_cos/o_sin stable. On i_ready, clear o_valid and go to IDLE. i_ready already high gives a one-cycle DONE.
- Latency: accept edge to o_valid = N_ITER+2 cycles. Minimum spacing between accepts = N_ITER+3 cycles.
- o_ready=0 outside IDLE; i_valid is ignored there.
- If eng_valid_o is low in any cycle where feedback is used (k>=1 or FIX), the controller is in protocol error: it returns to IDLE without o_valid.
- eng_quadrant is driven with the stored q throughout. Engine out_quadrant is not used.

Decomposition:
- Package cordic_pkg holds: KSCALE function of DATA_WIDTH, state encoding localparams, and the ATAN table formula round(atan(2^-k)*2^DW/(2*pi)). For DW=18: k0=32768, k1=19344, k2=10221, ..., k15=1.
- Sub-module cordic_atan_rom: combinational, indexed by k, DATA_WIDTH output.

Test Plan:
- Phase 0x00000, i_ready=1 -> o_valid exactly 18 cycles after accept; o_cos=65536±8, o_sin=0±8.
- Phase 0x08000 (pi/4) -> o_cos=o_sin=46341±8.
- Phases 0x10000, 0x20000, 0x30000 -> (cos,sin) = (0,65536), (-65536,0), (0,-65536), each ±8. Checks all quadrant corrections.
- Back-to-back i_valid held high with i_ready low for 5 cycles after o_valid -> o_valid and outputs stable; o_ready=0 until the DONE handshake; next phase accepted on the cycle after o_ready rises.
- Assert i_rst for 1 cycle at ITER k=7 -> outputs zero immediately (async); no o_valid; a fresh phase 0x04000 then completes with correct values (cos=60547±8, sin=25080±8).
- Engine model drops eng_valid_o at k=5 -> return to IDLE, no o_valid, o_ready=1 the next cycle.
